// File: rtl/plab5_mcore_mem_sec_tracker_pkg.sv
// rtl/plab5_mcore_mem_sec_tracker_pkg.sv - shared widths and level encoding for the security tracker
package plab5_mcore_mem_sec_tracker_pkg;

    localparam logic SEC_LOW  = 1'b0;
    localparam logic SEC_HIGH = 1'b1;

    localparam int MEM_TYPE_NBITS = 3;
    localparam int MEM_TEST_NBITS = 2;

    // Length field counts bytes of the data word, so it scales with data width.
    function automatic int mem_len_nbits(input int d);
        return $clog2(d / 8);
    endfunction

    function automatic int mem_req_msg_nbits(input int o, input int a, input int d);
        return MEM_TYPE_NBITS + o + a + mem_len_nbits(d) + d;
    endfunction

    function automatic int mem_resp_msg_nbits(input int o, input int d);
        return MEM_TYPE_NBITS + o + MEM_TEST_NBITS + mem_len_nbits(d) + d;
    endfunction

endpackage

// File: rtl/plab5_mcore_mem_sec_tracker_sec_fifo.sv
// rtl/plab5_mcore_mem_sec_tracker_sec_fifo.sv - count-based FIFO with same-cycle push and pop
module plab5_mcore_sec_fifo #(
    parameter int p_nbits   = 1,
    parameter int p_entries = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_val,
    output logic                         enq_rdy,
    input  logic [p_nbits-1:0]           enq_msg,
    output logic                         deq_val,
    input  logic                         deq_rdy,
    output logic [p_nbits-1:0]           deq_msg,
    output logic [$clog2(p_entries):0]   count
);

    localparam int ptr_nbits = $clog2(p_entries);
    localparam int cnt_nbits = ptr_nbits + 1;

    logic [p_nbits-1:0]   mem_q [p_entries];
    logic [ptr_nbits-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_nbits-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_nbits-1:0] count_q, count_d;
    logic                 do_enq, do_deq;

    always_comb begin
        enq_rdy = (count_q != cnt_nbits'(p_entries));
        deq_val = (count_q != '0);
        // Empty queue presents zeros so level outputs read low, not stale data.
        deq_msg = deq_val ? mem_q[rd_ptr_q] : '0;
        count   = count_q;
    end

    always_comb begin
        do_enq   = enq_val && enq_rdy;
        do_deq   = deq_val && deq_rdy;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_enq) wr_ptr_d = wr_ptr_q + ptr_nbits'(1);
        if (do_deq) rd_ptr_d = rd_ptr_q + ptr_nbits'(1);
        count_d = count_q + cnt_nbits'(do_enq) - cnt_nbits'(do_deq);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem_q[wr_ptr_q] <= enq_msg;
    end

endmodule

// File: rtl/plab5_mcore_mem_sec_tracker.sv
// rtl/plab5_mcore_mem_sec_tracker.sv - buffers requests and tags each response with its request's level
module plab5_mcore_mem_sec_tracker
    import plab5_mcore_mem_sec_tracker_pkg::*;
#(
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_req_entries     = 4,
    parameter int p_max_outstanding = 4,
    parameter int req_cnbits  = mem_req_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits) - p_data_nbits,
    parameter int resp_cnbits = mem_resp_msg_nbits(p_opaque_nbits, p_data_nbits) - p_data_nbits
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic                                 in_req_sec_level,
    input  logic [req_cnbits-1:0]                in_req_control,
    input  logic [p_data_nbits-1:0]              in_req_data,
    input  logic                                 in_req_val,
    output logic                                 in_req_rdy,

    output logic                                 out_req_sec_level,
    output logic [req_cnbits-1:0]                out_req_control,
    output logic [p_data_nbits-1:0]              out_req_data,
    output logic                                 out_req_val,
    input  logic                                 out_req_rdy,

    input  logic [resp_cnbits-1:0]               acc_resp_control,
    input  logic [p_data_nbits-1:0]              acc_resp_data,
    input  logic                                 acc_resp_val,
    output logic                                 acc_resp_rdy,

    output logic                                 out_resp_sec_level,
    output logic [resp_cnbits-1:0]               out_resp_control,
    output logic [p_data_nbits-1:0]              out_resp_data,
    output logic                                 out_resp_val,
    input  logic                                 out_resp_rdy,

    output logic [$clog2(p_max_outstanding):0]   outstanding,
    output logic                                 orphan_resp
);

    localparam int req_nbits = 1 + req_cnbits + p_data_nbits;

    logic [req_nbits-1:0]               req_enq_msg, req_deq_msg;
    logic                               req_enq_rdy, req_deq_val, req_deq_rdy;
    logic [$clog2(p_req_entries):0]     req_count_unused;

    logic [0:0]                         tag_enq_msg, tag_deq_msg;
    logic                               tag_enq_val, tag_enq_rdy;
    logic                               tag_deq_val, tag_deq_rdy;
    logic [$clog2(p_max_outstanding):0] tag_count;

    logic                               tag_full, issue;
    logic                               orphan_resp_q, orphan_resp_d;

    assign req_enq_msg = {in_req_sec_level, in_req_control, in_req_data};

    plab5_mcore_sec_fifo #(
        .p_nbits   (req_nbits),
        .p_entries (p_req_entries)
    ) req_buf (
        .clk     (clk),
        .reset   (reset),
        .enq_val (in_req_val),
        .enq_rdy (req_enq_rdy),
        .enq_msg (req_enq_msg),
        .deq_val (req_deq_val),
        .deq_rdy (req_deq_rdy),
        .deq_msg (req_deq_msg),
        .count   (req_count_unused)
    );

    plab5_mcore_sec_fifo #(
        .p_nbits   (1),
        .p_entries (p_max_outstanding)
    ) tag_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (tag_enq_val),
        .enq_rdy (tag_enq_rdy),
        .enq_msg (tag_enq_msg),
        .deq_val (tag_deq_val),
        .deq_rdy (tag_deq_rdy),
        .deq_msg (tag_deq_msg),
        .count   (tag_count)
    );

    // Request side: a full tag queue holds issue back so every issued request has a slot.
    always_comb begin
        in_req_rdy        = req_enq_rdy;
        tag_full          = !tag_enq_rdy;
        out_req_val       = req_deq_val && !tag_full;
        req_deq_rdy       = out_req_rdy && !tag_full;
        issue             = out_req_val && out_req_rdy;
        out_req_sec_level = req_deq_msg[req_nbits-1];
        out_req_control   = req_deq_msg[p_data_nbits +: req_cnbits];
        out_req_data      = req_deq_msg[p_data_nbits-1:0];
        tag_enq_val       = issue;
        tag_enq_msg       = req_deq_msg[req_nbits-1 -: 1];
    end

    // Response side: with no tag the beat is accepted and dropped as an orphan.
    always_comb begin
        out_resp_control   = acc_resp_control;
        out_resp_data      = acc_resp_data;
        out_resp_sec_level = tag_deq_msg[0];
        out_resp_val       = tag_deq_val && acc_resp_val;
        acc_resp_rdy       = tag_deq_val ? out_resp_rdy : 1'b1;
        tag_deq_rdy        = acc_resp_val && out_resp_rdy;
        orphan_resp_d      = acc_resp_val && !tag_deq_val;
        outstanding        = tag_count;
        orphan_resp        = orphan_resp_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) orphan_resp_q <= 1'b0;
        else        orphan_resp_q <= orphan_resp_d;
    end

endmodule

// File: tb/tb_plab5_mcore_mem_sec_tracker.sv
// tb/tb_plab5_mcore_mem_sec_tracker.sv - vectors, directed sequences and a queue model for the tracker
module tb_plab5_mcore_mem_sec_tracker;
    import plab5_mcore_mem_sec_tracker_pkg::*;

    localparam int O = 8, A = 32, D = 32, DEPTH = 4;
    localparam int RQC = mem_req_msg_nbits(O, A, D) - D;
    localparam int RSC = mem_resp_msg_nbits(O, D) - D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           in_req_sec_level, in_req_val, in_req_rdy;
    logic [RQC-1:0] in_req_control, out_req_control;
    logic [D-1:0]   in_req_data, out_req_data;
    logic           out_req_sec_level, out_req_val, out_req_rdy;
    logic [RSC-1:0] acc_resp_control, out_resp_control;
    logic [D-1:0]   acc_resp_data, out_resp_data;
    logic           acc_resp_val, acc_resp_rdy;
    logic           out_resp_sec_level, out_resp_val, out_resp_rdy;
    logic [2:0]     outstanding;
    logic           orphan_resp;

    plab5_mcore_mem_sec_tracker dut (
        .clk(clk), .reset(reset),
        .in_req_sec_level(in_req_sec_level), .in_req_control(in_req_control),
        .in_req_data(in_req_data), .in_req_val(in_req_val), .in_req_rdy(in_req_rdy),
        .out_req_sec_level(out_req_sec_level), .out_req_control(out_req_control),
        .out_req_data(out_req_data), .out_req_val(out_req_val), .out_req_rdy(out_req_rdy),
        .acc_resp_control(acc_resp_control), .acc_resp_data(acc_resp_data),
        .acc_resp_val(acc_resp_val), .acc_resp_rdy(acc_resp_rdy),
        .out_resp_sec_level(out_resp_sec_level), .out_resp_control(out_resp_control),
        .out_resp_data(out_resp_data), .out_resp_val(out_resp_val), .out_resp_rdy(out_resp_rdy),
        .outstanding(outstanding), .orphan_resp(orphan_resp)
    );

    typedef struct { logic sec; logic [RQC-1:0] ctrl; logic [D-1:0] data; } req_t;
    req_t req_q[$];
    bit   tag_q[$];
    bit   orphan_pend;

    int errors = 0, checks = 0;

    logic        s_in_rdy, s_oreq_val, s_oreq_sec, s_oresp_val, s_oresp_sec, s_acc_rdy, s_orphan;
    logic [31:0] s_oreq_data;
    logic [2:0]  s_outst;

    function automatic logic [RQC-1:0] mk_ctrl(input logic [31:0] d);
        logic [63:0] w;
        w = {d, ~d};
        return w[RQC-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check against the queue model, advance model at posedge.
    task automatic step(input bit rstn, input bit iv, input bit isec, input logic [31:0] idata,
                        input bit ordy, input bit av, input logic [31:0] adata, input bit rrdy);
        bit e_in_rdy, e_oreq_val, tag_ne;
        req_t r;
        @(negedge clk);
        reset = rstn; in_req_val = iv; in_req_sec_level = isec; in_req_data = idata;
        in_req_control = mk_ctrl(idata); out_req_rdy = ordy; acc_resp_val = av;
        acc_resp_data = adata; acc_resp_control = adata[RSC-1:0]; out_resp_rdy = rrdy;
        #1;
        s_in_rdy = in_req_rdy; s_oreq_val = out_req_val; s_oreq_sec = out_req_sec_level;
        s_oreq_data = out_req_data; s_oresp_val = out_resp_val; s_oresp_sec = out_resp_sec_level;
        s_acc_rdy = acc_resp_rdy; s_outst = outstanding; s_orphan = orphan_resp;
        e_in_rdy   = req_q.size() < DEPTH;
        e_oreq_val = req_q.size() > 0 && tag_q.size() < DEPTH;
        tag_ne     = tag_q.size() > 0;
        chk("in_req_rdy", in_req_rdy, e_in_rdy);
        chk("out_req_val", out_req_val, e_oreq_val);
        if (e_oreq_val) begin
            chk("out_req_sec", out_req_sec_level, req_q[0].sec);
            chk("out_req_data", out_req_data, req_q[0].data);
            chk("out_req_ctrl", out_req_control, req_q[0].ctrl);
        end
        chk("out_resp_val", out_resp_val, tag_ne && av);
        chk("out_resp_sec", out_resp_sec_level, tag_ne ? tag_q[0] : 1'b0);
        chk("acc_resp_rdy", acc_resp_rdy, tag_ne ? rrdy : 1'b1);
        chk("outstanding", outstanding, tag_q.size());
        chk("orphan_resp", orphan_resp, orphan_pend);
        chk("resp_pass", {out_resp_control, out_resp_data}, {adata[RSC-1:0], adata});
        @(posedge clk);
        if (!rstn) begin
            req_q.delete(); tag_q.delete(); orphan_pend = 0;
        end else begin
            if (tag_ne && av && rrdy) void'(tag_q.pop_front());
            if (e_oreq_val && ordy) begin
                tag_q.push_back(req_q[0].sec);
                void'(req_q.pop_front());
            end
            if (iv && e_in_rdy) begin
                r.sec = isec; r.ctrl = mk_ctrl(idata); r.data = idata;
                req_q.push_back(r);
            end
            orphan_pend = !tag_ne && av;
        end
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input bit ordy);
        step(1, 0, 0, 0, ordy, 0, 0, 1);
    endtask

    typedef struct {
        bit iv; bit isec; logic [31:0] idata; bit ordy; bit av; logic [31:0] adata; bit rrdy;
        bit e_in_rdy; bit e_oreq_val; bit e_oreq_sec; logic [31:0] e_oreq_data;
        bit e_oresp_val; bit e_oresp_sec; bit e_acc_rdy; int e_outst; bit e_orphan;
    } vec_t;

    vec_t vecs[7];
    bit   got[5];
    bit   exp_lv[5];

    initial begin
        vecs[0] = '{1, 1, 32'hDEADBEEF, 1, 0, 0, 1,      1, 0, 0, 0,            0, 0, 1, 0, 0};
        vecs[1] = '{0, 0, 0,            1, 0, 0, 1,      1, 1, 1, 32'hDEADBEEF, 0, 0, 1, 0, 0};
        vecs[2] = '{0, 0, 0,            0, 1, 32'h55, 1, 1, 0, 0, 0,            1, 1, 1, 1, 0};
        vecs[3] = '{0, 0, 0,            0, 0, 0, 1,      1, 0, 0, 0,            0, 0, 1, 0, 0};
        vecs[4] = '{0, 0, 0,            0, 1, 32'h1234, 0, 1, 0, 0, 0,          0, 0, 1, 0, 0};
        vecs[5] = '{0, 0, 0,            0, 0, 0, 1,      1, 0, 0, 0,            0, 0, 1, 0, 1};
        vecs[6] = '{0, 0, 0,            0, 0, 0, 1,      1, 0, 0, 0,            0, 0, 1, 0, 0};
        exp_lv = '{1, 0, 0, 1, 1};

        reset = 0; in_req_val = 0; in_req_sec_level = 0; in_req_data = 0; in_req_control = 0;
        out_req_rdy = 0; acc_resp_val = 0; acc_resp_data = 0; acc_resp_control = 0; out_resp_rdy = 0;
        orphan_pend = 0;
        repeat (2) @(posedge clk);

        // Single request round trip and an orphan response, against fixed expectations.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1, vecs[i].iv, vecs[i].isec, vecs[i].idata, vecs[i].ordy,
                 vecs[i].av, vecs[i].adata, vecs[i].rrdy);
            chk($sformatf("vec%0d in_rdy", i), s_in_rdy, vecs[i].e_in_rdy);
            chk($sformatf("vec%0d oreq_val", i), s_oreq_val, vecs[i].e_oreq_val);
            if (vecs[i].e_oreq_val) begin
                chk($sformatf("vec%0d oreq_sec", i), s_oreq_sec, vecs[i].e_oreq_sec);
                chk($sformatf("vec%0d oreq_data", i), s_oreq_data, vecs[i].e_oreq_data);
            end
            chk($sformatf("vec%0d oresp_val", i), s_oresp_val, vecs[i].e_oresp_val);
            chk($sformatf("vec%0d oresp_sec", i), s_oresp_sec, vecs[i].e_oresp_sec);
            chk($sformatf("vec%0d acc_rdy", i), s_acc_rdy, vecs[i].e_acc_rdy);
            chk($sformatf("vec%0d outst", i), s_outst, vecs[i].e_outst);
            chk($sformatf("vec%0d orphan", i), s_orphan, vecs[i].e_orphan);
        end

        // Tag queue full: fifth request waits until the first response frees a slot.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, exp_lv[i], 32'hA000 + i, 1, 0, 0, 1);
        repeat (4) idle(1);
        chk("full_oreq_val", s_oreq_val, 0);
        chk("full_outst", s_outst, 4);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 1, 1, 32'hB0 + i, 1);
            got[i] = s_oresp_sec;
            if (i == 0) chk("full_hold_first_pop", s_oreq_val, 0);
            if (i == 1) chk("full_issue_after_pop", s_oreq_val, 1);
        end
        for (int i = 0; i < 5; i++) chk($sformatf("full_tag%0d", i), got[i], exp_lv[i]);

        // Request buffer backpressure, then in-order release.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 1, i[0], 32'hC0 + i, 0, 0, 0, 1);
            if (i == 3) chk("bp_rdy_before_full", s_in_rdy, 1);
            if (i == 4) chk("bp_rdy_full", s_in_rdy, 0);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk($sformatf("bp_order%0d", i), s_oreq_data, 32'hC0 + i);
        end
        repeat (4) step(1, 0, 0, 0, 0, 1, 32'h9, 1);

        // Simultaneous issue and response with two outstanding.
        do_reset();
        step(1, 1, 1, 32'hD0, 0, 0, 0, 1);
        step(1, 1, 0, 32'hD1, 0, 0, 0, 1);
        step(1, 1, 1, 32'hD2, 0, 0, 0, 1);
        idle(1);
        idle(1);
        step(1, 0, 0, 0, 1, 1, 32'hE0, 1);
        chk("simul_outst", s_outst, 2);
        chk("simul_oldest_tag", s_oresp_sec, 1);
        chk("simul_issue", s_oreq_val, 1);
        idle(0);
        chk("simul_outst_after", s_outst, 2);
        chk("simul_next_tag", s_oresp_sec, 0);

        // Reset with 3 buffered and 2 outstanding; later response is an orphan.
        do_reset();
        step(1, 1, 1, 32'hF0, 1, 0, 0, 1);
        step(1, 1, 0, 32'hF1, 1, 0, 0, 1);
        step(1, 1, 1, 32'hF2, 1, 0, 0, 1);
        step(1, 1, 0, 32'hF3, 0, 0, 0, 1);
        step(1, 1, 1, 32'hF4, 0, 0, 0, 1);
        idle(0);
        chk("mid_outst_pre", s_outst, 2);
        do_reset();
        step(1, 0, 0, 0, 0, 1, 32'h77, 1);
        chk("mid_in_rdy", s_in_rdy, 1);
        chk("mid_oreq_val", s_oreq_val, 0);
        chk("mid_outst", s_outst, 0);
        chk("mid_oresp_val", s_oresp_val, 0);
        chk("mid_acc_rdy", s_acc_rdy, 1);
        idle(0);
        chk("mid_orphan", s_orphan, 1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 97) != 0, $urandom % 2, $urandom % 2, $urandom,
                 ($urandom % 4) != 0, ($urandom % 3) == 0, $urandom, ($urandom % 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
